// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared game constants and types: Tom sprite geometry, animation set
//   numbering, the colour key, the sprite_control bit layout (shared with
//   host_move_ctrl), and the VGA timing bundle carried down the draw chain.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int          TOM_WIDTH  = 48;
    localparam int          TOM_HEIGHT = 32;
    localparam int          TOM_FRAMES = 8;
    localparam logic [11:0] TRANSP_RGB = 12'hF0F;

    typedef enum logic [1:0] {
        SPRITE_SET_RUN  = 2'd0,
        SPRITE_SET_IDLE = 2'd1,
        SPRITE_SET_JUMP = 2'd2
    } sprite_set_t;

    // sprite_control = {right, jump, idle, frame[3:0]}
    localparam int CTL_W         = 7;
    localparam int CTL_RIGHT     = 6;
    localparam int CTL_JUMP      = 5;
    localparam int CTL_IDLE      = 4;
    localparam int CTL_FRAME_LSB = 0;
    localparam int CTL_FRAME_W   = 4;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

endpackage

// File: rtl/pos_if.sv
// ---------------------------------------------------------------------------
// pos_if
//   Sprite position bundle: x[9:0], y[9:0] = top-left corner in pixels.
//   Modport 'out' for the producer (movement controller), 'in' for drawers.
// ---------------------------------------------------------------------------
interface pos_if;
    logic [9:0] x;
    logic [9:0] y;

    modport in  (input x, input y);
    modport out (output x, output y);
endinterface

// File: rtl/host_sprite_rom.sv
// ---------------------------------------------------------------------------
// host_sprite_rom
//   Synchronous single-port ROM holding the Tom animation sets, 12-bit RGB
//   words, one clock read latency. Layout: set-major, then frame, row, column.
//   The image is a built-in address-derived art pattern so the ROM needs no
//   load file; every address whose low nibble is 5 holds the colour key.
// Ports:
//   clk   in   clock
//   addr  in   word address (registered by the caller)
//   data  out  word at addr, one clock later
// ---------------------------------------------------------------------------
module host_sprite_rom
    import game_pkg::*;
#(
    parameter int          DEPTH   = 3 * TOM_FRAMES * TOM_WIDTH * TOM_HEIGHT,
    parameter int          ADDR_W  = $clog2(DEPTH),
    parameter logic [11:0] KEY_RGB = TRANSP_RGB
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [11:0]       data
);

    logic [11:0] data_d;
    logic [11:0] data_q;

    function automatic logic [11:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a[3:0] == 4'h5) begin
            return KEY_RGB;
        end
        return 12'(a) ^ 12'(a >> 12);
    endfunction

    always_comb begin
        data_d = rom_word(addr);
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/draw_host_sprite.sv
// ---------------------------------------------------------------------------
// draw_host_sprite
//   Overlays the animated Tom sprite on the VGA pixel stream. Position and
//   sprite_control are captured once per frame at the rising edge of vblank,
//   so a frame is always drawn from one consistent snapshot.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   hcount_in .. vblnk_in    incoming pixel timing
//   rgb_in                   upstream pixel colour
//   tom_pos                  sprite top-left corner (pos_if.in)
//   sprite_control           {right, jump, idle, frame[3:0]}
//   hcount_out .. vblnk_out  timing delayed by 2 clk
//   rgb_out                  composed pixel, aligned with delayed timing
// ---------------------------------------------------------------------------
module draw_host_sprite
    import game_pkg::*;
#(
    parameter int          SPRITE_W   = TOM_WIDTH,
    parameter int          SPRITE_H   = TOM_HEIGHT,
    parameter int          FRAMES     = TOM_FRAMES,
    parameter logic [11:0] TRANSP_RGB = game_pkg::TRANSP_RGB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      hcount_in,
    input  logic [10:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_in,
    pos_if.in                tom_pos,
    input  logic [CTL_W-1:0] sprite_control,
    output logic [10:0]      hcount_out,
    output logic [10:0]      vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out
);

    localparam int DEPTH   = 3 * FRAMES * SPRITE_W * SPRITE_H;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    // Per-frame snapshot
    logic [9:0]       shadow_x_d, shadow_x_q;
    logic [9:0]       shadow_y_d, shadow_y_q;
    logic [CTL_W-1:0] shadow_ctl_d, shadow_ctl_q;
    logic             shadow_valid_d, shadow_valid_q;
    logic             vblank_rise;

    // Stage 0 (combinational on inputs)
    logic [11:0]            h12, v12, x12, y12, dx_raw, dx, dy;
    logic                   in_box, hit_p0;
    sprite_set_t            set_sel;
    logic [CTL_FRAME_W-1:0] frame_mod;
    logic [FRAME_W-1:0]     frame_sel;
    logic [ADDR_W-1:0]      addr_p0;

    // Pipeline registers
    vga_t              tm_p1_d, tm_p1_q, tm_p2_d, tm_p2_q;
    logic              hit_p1_d, hit_p1_q, hit_p2_d, hit_p2_q;
    logic [ADDR_W-1:0] addr_p1_d, addr_p1_q;
    logic [11:0]       rom_rgb;

    // tm_p1_q.vblnk doubles as the previous-cycle vblank for edge detection.
    always_comb begin
        vblank_rise    = vblnk_in && !tm_p1_q.vblnk;
        shadow_x_d     = shadow_x_q;
        shadow_y_d     = shadow_y_q;
        shadow_ctl_d   = shadow_ctl_q;
        shadow_valid_d = shadow_valid_q;
        if (vblank_rise) begin
            shadow_x_d     = tom_pos.x;
            shadow_y_d     = tom_pos.y;
            shadow_ctl_d   = sprite_control;
            shadow_valid_d = 1'b1;
        end
    end

    // ---- stage 0: hit test and ROM address ----
    // Box bounds are 12 bits wide so x + W past 1023 cannot wrap to column 0.
    always_comb begin
        h12    = {1'b0, hcount_in};
        v12    = {1'b0, vcount_in};
        x12    = {2'b00, shadow_x_q};
        y12    = {2'b00, shadow_y_q};
        in_box = (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
                 (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
        hit_p0 = shadow_valid_q && !hblnk_in && !vblnk_in && in_box;
        dx_raw = h12 - x12;
        dy     = v12 - y12;
        // Art faces right; facing left reads each row back to front.
        dx     = shadow_ctl_q[CTL_RIGHT] ? dx_raw : (12'(SPRITE_W - 1) - dx_raw);

        if (shadow_ctl_q[CTL_JUMP]) begin
            set_sel = SPRITE_SET_JUMP;
        end else if (shadow_ctl_q[CTL_IDLE]) begin
            set_sel = SPRITE_SET_IDLE;
        end else begin
            set_sel = SPRITE_SET_RUN;
        end
        frame_mod = shadow_ctl_q[CTL_FRAME_LSB +: CTL_FRAME_W] % CTL_FRAME_W'(FRAMES);
        frame_sel = (set_sel == SPRITE_SET_IDLE) ? '0 : FRAME_W'(frame_mod);

        addr_p0 = ((ADDR_W'(set_sel) * ADDR_W'(FRAMES) + ADDR_W'(frame_sel))
                   * ADDR_W'(SPRITE_H) + ADDR_W'(dy)) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);
    end

    always_comb begin
        tm_p1_d.hcount = hcount_in;
        tm_p1_d.vcount = vcount_in;
        tm_p1_d.hsync  = hsync_in;
        tm_p1_d.vsync  = vsync_in;
        tm_p1_d.hblnk  = hblnk_in;
        tm_p1_d.vblnk  = vblnk_in;
        tm_p1_d.rgb    = rgb_in;
        hit_p1_d       = hit_p0;
        addr_p1_d      = addr_p0;
        tm_p2_d        = tm_p1_q;
        hit_p2_d       = hit_p1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_x_q     <= '0;
            shadow_y_q     <= '0;
            shadow_ctl_q   <= '0;
            shadow_valid_q <= 1'b0;
            tm_p1_q        <= '0;
            hit_p1_q       <= 1'b0;
            addr_p1_q      <= '0;
            tm_p2_q        <= '0;
            hit_p2_q       <= 1'b0;
        end else begin
            shadow_x_q     <= shadow_x_d;
            shadow_y_q     <= shadow_y_d;
            shadow_ctl_q   <= shadow_ctl_d;
            shadow_valid_q <= shadow_valid_d;
            // ---- stage 1: registered address feeds the ROM ----
            tm_p1_q        <= tm_p1_d;
            hit_p1_q       <= hit_p1_d;
            addr_p1_q      <= addr_p1_d;
            // ---- stage 2: ROM data aligned with delayed timing ----
            tm_p2_q        <= tm_p2_d;
            hit_p2_q       <= hit_p2_d;
        end
    end

    host_sprite_rom #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .KEY_RGB (TRANSP_RGB)
    ) u_rom (
        .clk  (clk),
        .addr (addr_p1_q),
        .data (rom_rgb)
    );

    assign hcount_out = tm_p2_q.hcount;
    assign vcount_out = tm_p2_q.vcount;
    assign hsync_out  = tm_p2_q.hsync;
    assign vsync_out  = tm_p2_q.vsync;
    assign hblnk_out  = tm_p2_q.hblnk;
    assign vblnk_out  = tm_p2_q.vblnk;
    assign rgb_out    = (hit_p2_q && (rom_rgb != TRANSP_RGB)) ? rom_rgb : tm_p2_q.rgb;

endmodule

// File: tb/tb_draw_host_sprite.sv
module tb_draw_host_sprite;

    localparam int W = 48;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  sprite_control;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int errors = 0;
    int checks = 0;

    // Bench-side copy of what the DUT should have latched at the last vblank
    int       m_x, m_y;
    logic [6:0] m_ctl;
    logic     m_valid;

    pos_if tom_pos_if ();

    draw_host_sprite dut (
        .clk            (clk),
        .rst            (rst),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .hblnk_in       (hblnk_in),
        .vblnk_in       (vblnk_in),
        .rgb_in         (rgb_in),
        .tom_pos        (tom_pos_if),
        .sprite_control (sprite_control),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .hblnk_out      (hblnk_out),
        .vblnk_out      (vblnk_out),
        .rgb_out        (rgb_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Test art: key colour where address low nibble is 5, otherwise
    // the low 12 address bits xor the bits above them.
    function automatic logic [11:0] model_rom(input int a);
        if (a % 16 == 5) return 12'hF0F;
        return 12'(a % 4096) ^ 12'(a / 4096);
    endfunction

    function automatic logic [11:0] model_pix(input int h, input int v, input logic [11:0] c);
        int set, fr, dx, a;
        logic [11:0] p;
        if (!m_valid || h < m_x || h >= m_x + W || v < m_y || v >= m_y + H) return c;
        set = m_ctl[5] ? 2 : (m_ctl[4] ? 1 : 0);
        fr  = (set == 1) ? 0 : (int'(m_ctl[3:0]) % 8);
        dx  = m_ctl[6] ? (h - m_x) : (W - 1 - (h - m_x));
        a   = ((set * 8 + fr) * H + (v - m_y)) * W + dx;
        p   = model_rom(a);
        return (p == 12'hF0F) ? c : p;
    endfunction

    // Drive pixel P for one clock, then an unrelated filler pixel; return
    // #1 after the second rising edge, where P must be on the outputs.
    task automatic probe(input int h, input int v, input logic [11:0] c, input logic hb);
        @(negedge clk);
        hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = c;
        hblnk_in = hb; vblnk_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
        @(negedge clk);
        hcount_in = ~11'(h); vcount_in = ~11'(v); rgb_in = ~c;
        hblnk_in = ~hb; hsync_in = 1'b0; vsync_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_inputs(input int x, input int y, input logic [6:0] ctl);
        tom_pos_if.x   = 10'(x);
        tom_pos_if.y   = 10'(y);
        sprite_control = ctl;
    endtask

    task automatic do_vblank();
        @(negedge clk);
        hblnk_in = 1'b1; vblnk_in = 1'b1;
        @(negedge clk);
        vblnk_in = 1'b0; hblnk_in = 1'b0;
        m_x = int'(tom_pos_if.x); m_y = int'(tom_pos_if.y);
        m_ctl = sprite_control; m_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hcount_in = 11'd123; vcount_in = 11'd45; rgb_in = 12'hFFF;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b0;
        set_inputs(0, 0, 7'b1010000);
        m_x = 0; m_y = 0; m_ctl = '0; m_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb_out); end
        checks++; if (hcount_out !== 11'd0) begin errors++; $display("FAIL reset_hcount got=%0d exp=0", hcount_out); end
        checks++; if (vcount_out !== 11'd0) begin errors++; $display("FAIL reset_vcount got=%0d exp=0", vcount_out); end
        checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000) begin
            errors++; $display("FAIL reset_sync got=%b exp=0000", {hsync_out, vsync_out, hblnk_out, vblnk_out});
        end
        @(negedge clk);
        rst = 1'b0;
        // Shadow box is (0,0) but nothing latched yet: no sprite.
        probe(10, 10, 12'h123, 1'b0);
        checks++; if (rgb_out !== 12'h123) begin errors++; $display("FAIL prelatch_rgb got=%h exp=123", rgb_out); end
        checks++; if (hcount_out !== 11'd10) begin errors++; $display("FAIL prelatch_hcount got=%0d exp=10", hcount_out); end
    endtask

    task automatic test_idle_draw();
        int xs [8] = '{500, 547, 500, 547, 499, 548, 500, 500};
        int ys [8] = '{600, 600, 631, 631, 600, 600, 599, 632};
        logic [11:0] exp;
        set_inputs(500, 600, 7'b1010000);
        do_vblank();
        probe(500, 600, 12'h0A5, 1'b0);
        checks++; if (rgb_out !== 12'h003) begin errors++; $display("FAIL idle_corner got=%h exp=003", rgb_out); end
        checks++; if (hcount_out !== 11'd500) begin errors++; $display("FAIL lat_hcount got=%0d exp=500", hcount_out); end
        checks++; if (vcount_out !== 11'd600) begin errors++; $display("FAIL lat_vcount got=%0d exp=600", vcount_out); end
        checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b1000) begin
            errors++; $display("FAIL lat_sync got=%b exp=1000", {hsync_out, vsync_out, hblnk_out, vblnk_out});
        end
        for (int i = 0; i < 8; i++) begin
            exp = model_pix(xs[i], ys[i], 12'h0A5 + 12'(i));
            probe(xs[i], ys[i], 12'h0A5 + 12'(i), 1'b0);
            checks++; if (rgb_out !== exp) begin errors++; $display("FAIL idle_box[%0d] got=%h exp=%h", i, rgb_out, exp); end
        end
        probe(510, 610, 12'h0C3, 1'b1);
        checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL hblank_pass got=%h exp=0C3", rgb_out); end
        checks++; if (hblnk_out !== 1'b1) begin errors++; $display("FAIL hblank_out got=%b exp=1", hblnk_out); end
    endtask

    task automatic test_mirror();
        logic [11:0] exp;
        set_inputs(500, 600, 7'b0000011);
        do_vblank();
        probe(500, 610, 12'h111, 1'b0);
        checks++; if (rgb_out !== 12'h40E) begin errors++; $display("FAIL left_x500 got=%h exp=40E", rgb_out); end
        probe(547, 610, 12'h111, 1'b0);
        checks++; if (rgb_out !== 12'h3E1) begin errors++; $display("FAIL left_x547 got=%h exp=3E1", rgb_out); end
        for (int dx = 1; dx < W; dx += 9) begin
            exp = model_pix(500 + dx, 615, 12'h222);
            probe(500 + dx, 615, 12'h222, 1'b0);
            checks++; if (rgb_out !== exp) begin errors++; $display("FAIL left_row dx=%0d got=%h exp=%h", dx, rgb_out, exp); end
        end
        set_inputs(500, 600, 7'b1000011);
        do_vblank();
        probe(547, 610, 12'h111, 1'b0);
        checks++; if (rgb_out !== 12'h40E) begin errors++; $display("FAIL right_x547 got=%h exp=40E", rgb_out); end
        probe(500, 610, 12'h111, 1'b0);
        checks++; if (rgb_out !== 12'h3E1) begin errors++; $display("FAIL right_x500 got=%h exp=3E1", rgb_out); end
    endtask

    task automatic test_transparent();
        probe(505, 610, 12'h2C7, 1'b0);
        checks++; if (rgb_out !== 12'h2C7) begin errors++; $display("FAIL key_pass got=%h exp=2C7", rgb_out); end
        probe(506, 610, 12'h2C7, 1'b0);
        checks++; if (rgb_out !== 12'h3E7) begin errors++; $display("FAIL key_neighbour got=%h exp=3E7", rgb_out); end
    endtask

    task automatic test_move_midframe();
        set_inputs(500, 600, 7'b1010000);
        do_vblank();
        probe(520, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h017) begin errors++; $display("FAIL pre_move got=%h exp=017", rgb_out); end
        set_inputs(520, 600, 7'b0100000);
        probe(500, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h003) begin errors++; $display("FAIL midframe_old got=%h exp=003", rgb_out); end
        probe(560, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h05A) begin errors++; $display("FAIL midframe_new got=%h exp=05A", rgb_out); end
        do_vblank();
        probe(500, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h05A) begin errors++; $display("FAIL moved_left_out got=%h exp=05A", rgb_out); end
        probe(520, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h029) begin errors++; $display("FAIL moved_jump_x520 got=%h exp=029", rgb_out); end
        probe(567, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h006) begin errors++; $display("FAIL moved_jump_x567 got=%h exp=006", rgb_out); end
        probe(568, 600, 12'h05A, 1'b0);
        checks++; if (rgb_out !== 12'h05A) begin errors++; $display("FAIL moved_right_out got=%h exp=05A", rgb_out); end
    endtask

    task automatic test_right_edge();
        set_inputs(1020, 100, 7'b1001011);
        do_vblank();
        probe(1020, 100, 12'h777, 1'b0);
        checks++; if (rgb_out !== 12'h201) begin errors++; $display("FAIL edge_x1020 got=%h exp=201", rgb_out); end
        probe(1023, 100, 12'h777, 1'b0);
        checks++; if (rgb_out !== 12'h202) begin errors++; $display("FAIL edge_x1023 got=%h exp=202", rgb_out); end
        probe(1019, 100, 12'h777, 1'b0);
        checks++; if (rgb_out !== 12'h777) begin errors++; $display("FAIL edge_x1019 got=%h exp=777", rgb_out); end
        probe(0, 100, 12'h777, 1'b0);
        checks++; if (rgb_out !== 12'h777) begin errors++; $display("FAIL nowrap_x0 got=%h exp=777", rgb_out); end
        probe(3, 100, 12'h777, 1'b0);
        checks++; if (rgb_out !== 12'h777) begin errors++; $display("FAIL nowrap_x3 got=%h exp=777", rgb_out); end
    endtask

    task automatic test_reset_midline();
        probe(1021, 100, 12'h3C3, 1'b0);
        checks++; if (rgb_out !== 12'h200) begin errors++; $display("FAIL before_rst got=%h exp=200", rgb_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL async_rst_rgb got=%h exp=000", rgb_out); end
        checks++; if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== 26'd0) begin
            errors++; $display("FAIL async_rst_timing got=%0d/%0d exp=0/0", hcount_out, vcount_out);
        end
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        probe(1021, 100, 12'h3C3, 1'b0);
        checks++; if (rgb_out !== 12'h3C3) begin errors++; $display("FAIL post_rst_nodraw got=%h exp=3C3", rgb_out); end
        do_vblank();
        probe(1021, 100, 12'h3C3, 1'b0);
        checks++; if (rgb_out !== 12'h200) begin errors++; $display("FAIL post_rst_relatch got=%h exp=200", rgb_out); end
    endtask

    initial begin
        test_reset();
        test_idle_draw();
        test_mirror();
        test_transparent();
        test_move_midframe();
        test_right_edge();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
